// File: rtl/reg_file_sb.sv
// Integer register file with write-through bypass and a per-register pending-write scoreboard.
// Register 0 reads as zero; out-of-range indices read as zero and ignore writes and claims.
module reg_file_sb #(
    parameter int          DATA_W   = 32,
    parameter int          NUM_REGS = 32,
    parameter int          NUM_RD   = 2,
    parameter int          SP_IDX   = 29,
    parameter logic [31:0] SP_INIT  = 32'h0000FFFF,
    parameter int          DBG_IDX  = 31,
    localparam int         AW       = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_sel,
    output logic [NUM_RD*DATA_W-1:0] rd_val,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_sel,
    input  logic [DATA_W-1:0]        wr_val,
    input  logic                     claim_en,
    input  logic [AW-1:0]            claim_sel,
    output logic [NUM_REGS-1:0]      busy_vec,
    output logic [DATA_W-1:0]        dbg_val
);

    localparam logic [31:0]       NREGS  = 32'(NUM_REGS);
    localparam logic [DATA_W-1:0] SP_RST = DATA_W'(SP_INIT);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic                wr_hit;
    logic                claim_hit;

    // True for an index that names a real, writable register.
    function automatic logic idx_ok(input logic [AW-1:0] idx);
        return (idx != '0) && (32'(idx) < NREGS);
    endfunction

    assign wr_hit    = wr_en && idx_ok(wr_sel);
    assign claim_hit = claim_en && idx_ok(claim_sel);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == SP_IDX && i != 0) ? SP_RST : '0;
            end
        end else if (wr_hit) begin
            regs[wr_sel] <= wr_val;
        end
    end

    // A claim overrides a same-cycle writeback: a newer producer now owns the register.
    always_comb begin
        busy_nxt = busy;
        if (wr_hit) begin
            busy_nxt[wr_sel] = 1'b0;
        end
        if (claim_hit) begin
            busy_nxt[claim_sel] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign busy_vec = busy;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [AW-1:0] s;
        logic          ok;
        logic          byp;

        assign s   = rd_sel[g*AW +: AW];
        assign ok  = idx_ok(s);
        assign byp = wr_en && (wr_sel == s);
        assign rd_val[g*DATA_W +: DATA_W] = !ok ? '0 : (byp ? wr_val : regs[s]);
        assign rd_busy[g] = ok && busy[s] && !byp;
    end

    if (DBG_IDX >= 0 && DBG_IDX < NUM_REGS) begin : g_dbg
        assign dbg_val = regs[DBG_IDX];
    end else begin : g_dbg_none
        assign dbg_val = '0;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: default 32x32/2-port instance and a 24x16/3-port instance.
module tb_reg_file_sb;

    logic clk = 1'b0;
    logic rst;

    // Instance A: defaults (DATA_W 32, NUM_REGS 32, NUM_RD 2, AW 5)
    logic [9:0]  a_rd_sel;
    logic [63:0] a_rd_val;
    logic [1:0]  a_rd_busy;
    logic        a_wr_en;
    logic [4:0]  a_wr_sel;
    logic [31:0] a_wr_val;
    logic        a_claim_en;
    logic [4:0]  a_claim_sel;
    logic [31:0] a_busy_vec;
    logic [31:0] a_dbg_val;

    // Instance B: DATA_W 16, NUM_REGS 24, NUM_RD 3, AW 5
    logic [14:0] b_rd_sel;
    logic [47:0] b_rd_val;
    logic [2:0]  b_rd_busy;
    logic        b_wr_en;
    logic [4:0]  b_wr_sel;
    logic [15:0] b_wr_val;
    logic        b_claim_en;
    logic [4:0]  b_claim_sel;
    logic [23:0] b_busy_vec;
    logic [15:0] b_dbg_val;

    int checks = 0;
    int errors = 0;

    reg_file_sb u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .rd_sel    (a_rd_sel),
        .rd_val    (a_rd_val),
        .rd_busy   (a_rd_busy),
        .wr_en     (a_wr_en),
        .wr_sel    (a_wr_sel),
        .wr_val    (a_wr_val),
        .claim_en  (a_claim_en),
        .claim_sel (a_claim_sel),
        .busy_vec  (a_busy_vec),
        .dbg_val   (a_dbg_val)
    );

    reg_file_sb #(
        .DATA_W   (16),
        .NUM_REGS (24),
        .NUM_RD   (3),
        .SP_IDX   (5),
        .DBG_IDX  (23)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .rd_sel    (b_rd_sel),
        .rd_val    (b_rd_val),
        .rd_busy   (b_rd_busy),
        .wr_en     (b_wr_en),
        .wr_sel    (b_wr_sel),
        .wr_val    (b_wr_val),
        .claim_en  (b_claim_en),
        .claim_sel (b_claim_sel),
        .busy_vec  (b_busy_vec),
        .dbg_val   (b_dbg_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge, well clear of it.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        a_rd_sel = '0; a_wr_en = 1'b0; a_wr_sel = '0; a_wr_val = '0;
        a_claim_en = 1'b0; a_claim_sel = '0;
        b_rd_sel = '0; b_wr_en = 1'b0; b_wr_sel = '0; b_wr_val = '0;
        b_claim_en = 1'b0; b_claim_sel = '0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // Post-reset state
        a_rd_sel = {5'd5, 5'd29};
        #1;
        chk("a_rst_sp",    a_rd_val[31:0],  32'h0000FFFF);
        chk("a_rst_r5",    a_rd_val[63:32], 32'h0);
        chk("a_rst_busy",  a_busy_vec,      32'h0);
        chk("a_rst_rbusy", a_rd_busy,       2'b00);
        chk("a_rst_dbg",   a_dbg_val,       32'h0);

        // Seed r9, then bypass on r8 while port1 reads r9
        a_wr_en = 1'b1; a_wr_sel = 5'd9; a_wr_val = 32'h0000_0099;
        step();
        a_wr_sel = 5'd8; a_wr_val = 32'hDEADBEEF; a_rd_sel = {5'd9, 5'd8};
        #1;
        chk("byp_p0", a_rd_val[31:0],  32'hDEADBEEF);
        chk("byp_p1", a_rd_val[63:32], 32'h0000_0099);
        step();
        a_wr_en = 1'b0;
        #1;
        chk("byp_stored", a_rd_val[31:0], 32'hDEADBEEF);

        // Register zero: write and claim are both discarded
        a_wr_en = 1'b1; a_wr_sel = 5'd0; a_wr_val = 32'hFFFFFFFF;
        a_claim_en = 1'b1; a_claim_sel = 5'd0; a_rd_sel = {5'd0, 5'd0};
        #1;
        chk("r0_byp",   a_rd_val,  64'h0);
        chk("r0_rbusy", a_rd_busy, 2'b00);
        step();
        a_wr_en = 1'b0; a_claim_en = 1'b0;
        #1;
        chk("r0_val",   a_rd_val[31:0], 32'h0);
        chk("r0_bvec",  a_busy_vec,     32'h0);

        // Scoreboard life cycle on r10
        a_claim_en = 1'b1; a_claim_sel = 5'd10; a_rd_sel = {5'd0, 5'd10};
        #1;
        chk("sb_claim_same", a_rd_busy[0], 1'b0);
        step();
        a_claim_en = 1'b0;
        #1;
        chk("sb_bvec10", a_busy_vec[10], 1'b1);
        chk("sb_rbusy",  a_rd_busy[0],   1'b1);
        a_wr_en = 1'b1; a_wr_sel = 5'd10; a_wr_val = 32'h55;
        #1;
        chk("sb_wb_rbusy", a_rd_busy[0],   1'b0);
        chk("sb_wb_val",   a_rd_val[31:0], 32'h55);
        chk("sb_wb_bvec",  a_busy_vec[10], 1'b1);
        step();
        a_wr_en = 1'b0;
        #1;
        chk("sb_clear", a_busy_vec[10], 1'b0);
        chk("sb_val",   a_rd_val[31:0], 32'h55);

        // Claim and write to r12 together: claim wins, data still lands
        a_wr_en = 1'b1; a_wr_sel = 5'd12; a_wr_val = 32'h1212;
        a_claim_en = 1'b1; a_claim_sel = 5'd12;
        step();
        a_wr_sel = 5'd4; a_wr_val = 32'h44; a_claim_sel = 5'd3; a_rd_sel = {5'd4, 5'd12};
        #1;
        chk("cw_val12",  a_rd_val[31:0], 32'h1212);
        chk("cw_bvec12", a_busy_vec[12], 1'b1);
        chk("cw_rbusy",  a_rd_busy,      2'b01);
        step();
        a_wr_en = 1'b0; a_claim_en = 1'b0;
        #1;
        chk("cw_bvec",  a_busy_vec,      32'h0000_1008);
        chk("cw_val4",  a_rd_val[63:32], 32'h44);

        // dbg_val follows storage, not the bypass
        a_wr_en = 1'b1; a_wr_sel = 5'd31; a_wr_val = 32'hCAFE;
        #1;
        chk("dbg_same", a_dbg_val, 32'h0);
        step();
        a_wr_en = 1'b0;
        #1;
        chk("dbg_next", a_dbg_val, 32'hCAFE);

        // Mid-run asynchronous reset
        a_wr_en = 1'b1; a_wr_sel = 5'd5; a_wr_val = 32'h1234;
        a_claim_en = 1'b1; a_claim_sel = 5'd7; a_rd_sel = {5'd29, 5'd5};
        step();
        a_wr_en = 1'b0; a_claim_en = 1'b0;
        #1;
        chk("pre_rst_r5",   a_rd_val[31:0], 32'h1234);
        chk("pre_rst_b7",   a_busy_vec[7],  1'b1);
        rst = 1'b1;
        #1;
        chk("arst_r5",   a_rd_val[31:0],  32'h0);
        chk("arst_sp",   a_rd_val[63:32], 32'h0000FFFF);
        chk("arst_bvec", a_busy_vec,      32'h0);
        chk("arst_dbg",  a_dbg_val,       32'h0);
        a_wr_en = 1'b1; a_wr_sel = 5'd6; a_wr_val = 32'h66;
        a_claim_en = 1'b1; a_claim_sel = 5'd6;
        step();
        rst = 1'b0; a_wr_en = 1'b0; a_claim_en = 1'b0; a_rd_sel = {5'd0, 5'd6};
        #1;
        chk("arst_lost_wr", a_rd_val[31:0], 32'h0);
        chk("arst_lost_cl", a_busy_vec,     32'h0);

        // Instance B: SP at r5 truncated to 16 bits, out-of-range index 30
        b_rd_sel = {5'd0, 5'd0, 5'd5};
        #1;
        chk("b_rst_sp", b_rd_val[15:0], 16'hFFFF);
        b_wr_en = 1'b1; b_wr_sel = 5'd30; b_wr_val = 16'h1111;
        b_claim_en = 1'b1; b_claim_sel = 5'd30; b_rd_sel = {5'd0, 5'd0, 5'd30};
        #1;
        chk("b_oor_byp",   b_rd_val[15:0], 16'h0);
        chk("b_oor_rbusy", b_rd_busy,      3'b000);
        step();
        b_wr_en = 1'b0; b_claim_en = 1'b0;
        #1;
        chk("b_oor_val",  b_rd_val[15:0], 16'h0);
        chk("b_oor_bvec", b_busy_vec,     24'h0);

        b_wr_en = 1'b1; b_wr_sel = 5'd23; b_wr_val = 16'hA5A5;
        #1;
        chk("b_dbg_same", b_dbg_val, 16'h0);
        step();
        b_wr_en = 1'b0; b_rd_sel = {5'd23, 5'd23, 5'd23};
        #1;
        chk("b_all3",     b_rd_val,  48'hA5A5_A5A5_A5A5);
        chk("b_dbg_next", b_dbg_val, 16'hA5A5);

        b_claim_en = 1'b1; b_claim_sel = 5'd23;
        step();
        b_claim_en = 1'b0;
        #1;
        chk("b_rbusy3", b_rd_busy, 3'b111);
        b_wr_en = 1'b1; b_wr_val = 16'h5A5A;
        #1;
        chk("b_wb_rbusy", b_rd_busy, 3'b000);
        chk("b_wb_val",   b_rd_val,  48'h5A5A_5A5A_5A5A);
        step();
        b_wr_en = 1'b0;
        #1;
        chk("b_wb_bvec", b_busy_vec, 24'h0);
        chk("b_wb_dbg",  b_dbg_val,  16'h5A5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
